// File: rtl/serial_full_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_full_subtractor_pkg
//
// Shared definitions for the bit-serial subtractor:
//   - state_t   : controller state encoding (ST_IDLE, ST_RUN)
//   - cnt_width : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_full_subtractor_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The counter only ever holds 0..width-1, so $clog2(width) bits suffice.
    // The floor of 1 keeps the vector legal for the smallest widths.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_full_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//
// Single-bit combinational full-subtractor cell: d = a - b - bin.
//
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when the bits are equal and a
    // borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_full_subtractor.sv
// -----------------------------------------------------------------------------
// serial_full_subtractor
//
// Bit-serial WIDTH-bit unsigned subtractor computing d = a - b - bin one bit
// per clock, LSB first, through one full-subtractor cell and a registered
// borrow. A start/busy/done handshake sequences operations.
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset
//   start  in  1      request, sampled only while busy=0
//   a      in  WIDTH  minuend, captured on an accepted start
//   b      in  WIDTH  subtrahend, captured on an accepted start
//   bin    in  1      borrow in, captured on an accepted start
//   busy   out 1      operation in progress
//   done   out 1      one-cycle pulse when d/bout are updated
//   d      out WIDTH  difference, held until the next completion
//   bout   out 1      final borrow out, held with d
// -----------------------------------------------------------------------------
module serial_full_subtractor
    import serial_full_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             br_q, br_d;
    // Holds the WIDTH-1 bits already produced; the final bit joins them
    // on the MSB edge, so the full result never needs its own shift slot.
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (cell_diff),
        .bout (cell_borrow)
    );

    // New bit enters at the MSB; after WIDTH edges bit 0 is the first diff.
    assign res_next = {cell_diff, res_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            br_q    <= br_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        br_d    = br_q;
        res_d   = res_q;
        d_d     = d_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here: a request while
                // busy is dropped without disturbing the captured operands.
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                br_d   = cell_borrow;
                res_d  = res_next[WIDTH-1:1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    d_d     = res_next;
                    bout_d  = cell_borrow;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
module tb_serial_full_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] d;
    logic         bout;

    int errors = 0;
    int checks = 0;

    serial_full_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operands.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
        int unsigned diff;
        logic        brw;
        diff = (int'(ma) - int'(mb) - int'(mbin)) & ((1 << W) - 1);
        brw  = (int'(ma) < int'(mb) + int'(mbin));
        return {brw, diff[W-1:0]};
    endfunction

    // Issue one operation and check latency, busy profile, result and pulse width.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input int poke_at);
        logic [W:0] exp;
        int         k;
        int         busy_cnt;
        int         done_cnt;
        exp = model(ta, tb, tbin);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);                       // acceptance edge has passed
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        busy_cnt = busy ? 1 : 0;
        k = 0;
        while (!done && k < 3 * W) begin
            @(negedge clk);
            k++;
            if (k == poke_at) begin
                a = 8'hAA; b = 8'h11; bin = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, k, W);
        chk({tag, "_busycycles"}, busy_cnt, W);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_d"}, d, exp[W-1:0]);
        chk({tag, "_bout"}, bout, exp[W]);
        done_cnt = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk({tag, "_no_extra_done"}, done_cnt, 0);
        chk({tag, "_d_held"}, d, exp[W-1:0]);
    endtask

    logic [W:0] q_exp[$];
    logic [W:0] e;
    int         n_done;
    int         last_done;
    int         cyc;
    int         dcnt;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_d", d, 8'h00);
        chk("reset_bout", bout, 1'b0);
        rst = 1'b0;

        run_op("basic", 8'h5A, 8'h3C, 1'b0, -1);
        run_op("under0", 8'h00, 8'h01, 1'b0, -1);
        run_op("under1", 8'h10, 8'h10, 1'b1, -1);
        run_op("nobr0", 8'hFF, 8'h00, 1'b1, -1);
        run_op("nobr1", 8'h80, 8'h7F, 1'b0, -1);
        run_op("busystart", 8'h05, 8'h03, 1'b0, 3);
        chk("busystart_d_const", d, 8'h02);

        // Reset while the cnt=4 bit is being processed.
        @(negedge clk);
        a = 8'h33; b = 8'h22; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstrun_busy", busy, 1'b0);
        chk("rstrun_d", d, 8'h00);
        chk("rstrun_bout", bout, 1'b0);
        dcnt = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("rstrun_no_done", dcnt, 0);
        run_op("after_rst", 8'h09, 8'h04, 1'b0, -1);

        // Continuous start with random operands changing every cycle.
        n_done = 0; last_done = -1; cyc = 0;
        while (n_done < 200 && cyc < 200 * (W + 1) + 50) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (q_exp.size() == 0) begin
                    chk("b2b_queue_empty", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    chk("b2b_d", d, e[W-1:0]);
                    chk("b2b_bout", bout, e[W]);
                end
                if (last_done >= 0) chk("b2b_spacing", cyc - last_done, W + 1);
                last_done = cyc;
                n_done++;
            end
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'b1;
            if (!busy) q_exp.push_back(model(a, b, bin));
        end
        start = 1'b0;
        chk("b2b_count", n_done, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_full_subtractor.md
Name: serial_full_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes d = a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- It is the complementary arithmetic block to the team's registered full adder and shares its port style (a, b, s-style result, carry/borrow in/out, clk).
- Used where area matters more than latency. A start/busy/done handshake lets a controller sequence operations.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request. Sampled only when busy=0.
- a  in  WIDTH  minuend. Captured on an accepted start.
- b  in  WIDTH  subtrahend. Captured on an accepted start.
- bin  in  1  borrow-in. Captured on an accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when d and bout become valid.
- d  out  WIDTH  difference. Held until the next completion.
- bout  out  1  final borrow-out. Held with d.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state IDLE and clears the bit counter and shift registers.
  - Outputs: busy=0, done=0, d=0, bout=0.
  - rst has priority over every other input.
- States:
  - IDLE: busy=0. start=1 at an edge captures a into the A shift register, b into the B shift register and bin into the borrow register. Bit counter clears to 0. Next state is RUN.
  - RUN: busy=1. Each edge does the following:
    - Applies the full-subtractor cell to (A[0], B[0], borrow): diff = A0^B0^br, borrow_next = (~A0&B0) | (~(A0^B0)&br).
    - Shifts diff into the MSB of the result shift register, shifts A and B right, stores borrow_next, and increments the counter.
    - On the edge where counter = WIDTH-1 (the MSB edge), it also loads d with the completed result, loads bout with borrow_next, sets done=1 and moves to IDLE.
- Latency:
  - start sampled at edge E0 gives done=1 during the cycle after edge E0+WIDTH.
  - Exactly WIDTH RUN edges per operation.
- Handshake:
  - done is high for exactly one cycle.
  - busy falls at the same edge that raises done.
- Arithmetic (unsigned):
  - d = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin.
- Boundary conditions:
  - start while busy=1: ignored. Operands are not re-captured and no error is raised.
  - start high in the cycle done=1: the block is already IDLE, so the new operation is accepted. Back-to-back throughput is one result per WIDTH+1 cycles.
  - start held high continuously: the block restarts on every IDLE cycle, using the operands present at that edge.
  - Reset during RUN: the operation is aborted, no done is produced, and d/bout return to 0.
  - a, b and bin may change freely after acceptance. The block uses only the captured copies.
  - Counter width is $clog2(WIDTH); there is no wrap within a run because the exit happens at WIDTH-1.

Decomposition:
- Shared package:
  - state encoding constants (ST_IDLE, ST_RUN);
  - a counter-width helper function, $clog2-based.
- Sub-module full_subtractor:
  - purely combinational;
  - ports a, b, bin, d, bout;
  - instantiated once in the datapath.
- Top level contains the FSM, counter, shift registers and output registers.

Test Plan:
- Basic subtraction, WIDTH=8: a=0x5A, b=0x3C, bin=0, start pulse -> done exactly 8 cycles after acceptance edge +1, d=0x1E, bout=0; busy high for 8 cycles.
- Underflow: a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1. Then a=0x10, b=0x10, bin=1 -> d=0xFF, bout=1.
- No-borrow with borrow-in: a=0xFF, b=0x00, bin=1 -> d=0xFE, bout=0. Then a=0x80, b=0x7F, bin=0 -> d=0x01, bout=0.
- Start during busy: accept a=0x05, b=0x03. Three cycles later pulse start with a=0xAA, b=0x11 -> single done with d=0x02, bout=0; no second done.
- Reset mid-run: accept a=0x33, b=0x22, assert rst for 1 cycle at RUN bit 4 -> busy=0, done never pulses, d=0x00, bout=0. A new start afterwards with a=0x09, b=0x04 -> d=0x05.
- Back-to-back and random: hold start=1 over 200 random operand sets -> each done result matches the reference model (a-b-bin) mod 256 and its borrow, with spacing of 9 cycles between done pulses.
